// File: rtl/mul_fp_iter_pkg.sv
// Shared definitions for the iterative single-precision multiplier:
// field widths, exponent bias, saturated magnitude and FSM states.
package mul_fp_iter_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned MANT_W = FRAC_W + 1;
  localparam int unsigned PROD_W = 2 * MANT_W;
  localparam int unsigned BIAS   = 127;

  // Largest representable magnitude (sign bit prepended at use)
  localparam logic [EXP_W+FRAC_W-1:0] SAT_MAX = {8'hFE, 23'h7FFFFF};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mul_fp_iter.sv
// Iterative shift-add single-precision multiplier (hidden 1, no denormals,
// exponent field 0 means zero). Fixed latency: valid in the 26th cycle
// after start is accepted.
// Optional build macro: MUL_FP_ITER_ROUND_EN enables round-to-nearest-even;
// without it the fraction is truncated.
module mul_fp_iter
  import mul_fp_iter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        valid,
  output logic [31:0] o
);

  state_t              state;
  logic [31:0]         ra;
  logic [31:0]         rb;
  logic [PROD_W-1:0]   p;
  logic [4:0]          cnt;

  logic [MANT_W-1:0]   mant_a;
  logic [MANT_W-1:0]   mant_b;
  logic [4:0]          idx;
  logic [PROD_W-1:0]   addend;
  logic                sign;
  logic signed [9:0]   e;
  logic [FRAC_W-1:0]   frac;
  logic [31:0]         res;
`ifdef MUL_FP_ITER_ROUND_EN
  logic                guard;
  logic                sticky;
  logic [FRAC_W:0]     frac_rnd;
`endif

  assign mant_a = {1'b1, ra[FRAC_W-1:0]};
  assign mant_b = {1'b1, rb[FRAC_W-1:0]};
  assign sign   = ra[31] ^ rb[31];

  // Partial product for the current multiplier bit; counter runs 23..0 so
  // the bit index runs 0..23 (LSB first). The multiplicand is shifted up
  // instead of shifting the product down so no product bit is discarded.
  always_comb begin
    idx    = 5'd23 - cnt;
    addend = '0;
    if (mant_b[idx])
      addend = {{MANT_W{1'b0}}, mant_a} << idx;
  end

  // Normalisation, optional rounding, saturation and zero handling
  always_comb begin
    e = $signed({2'b00, ra[30:23]}) + $signed({2'b00, rb[30:23]}) - 10'sd127;
`ifdef MUL_FP_ITER_ROUND_EN
    guard  = 1'b0;
    sticky = 1'b0;
`endif
    if (p[PROD_W-1]) begin
      frac = p[46:24];
      e    = e + 10'sd1;
`ifdef MUL_FP_ITER_ROUND_EN
      guard  = p[23];
      sticky = |p[22:0];
`endif
    end else begin
      frac = p[45:23];
`ifdef MUL_FP_ITER_ROUND_EN
      guard  = p[22];
      sticky = |p[21:0];
`endif
    end
`ifdef MUL_FP_ITER_ROUND_EN
    frac_rnd = {1'b0, frac};
    if (guard && (sticky || frac[0]))
      frac_rnd = frac_rnd + 24'd1;
    // Carry-out leaves the fraction all-zero; only the exponent moves
    frac = frac_rnd[FRAC_W-1:0];
    if (frac_rnd[FRAC_W])
      e = e + 10'sd1;
`endif
    if (ra[30:23] == '0 || rb[30:23] == '0)
      res = '0;
    else if (e >= 10'sd255)
      res = {sign, SAT_MAX};
    else if (e <= 10'sd0)
      res = '0;
    else
      res = {sign, e[7:0], frac};
  end

  // Control FSM with shift-add datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      valid <= 1'b0;
      o     <= '0;
      ra    <= '0;
      rb    <= '0;
      p     <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          if (start) begin
            ra    <= a;
            rb    <= b;
            p     <= '0;
            cnt   <= 5'd23;
            busy  <= 1'b1;
            state <= MUL;
          end
        end
        MUL: begin
          p <= p + addend;
          if (cnt == '0)
            state <= NORM;
          else
            cnt <= cnt - 5'd1;
        end
        NORM: begin
          o     <= res;
          busy  <= 1'b0;
          valid <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_fp_iter.sv
// Self-checking bench for mul_fp_iter: directed vectors, random operands
// against an arithmetic reference, start-while-busy and reset-abort cases.
module tb_mul_fp_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        valid;
  logic [31:0] o;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  bit          round_en;
  logic [31:0] last_o;

  mul_fp_iter dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .valid (valid),
    .o     (o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer product of the 24-bit mantissas, then
  // normalise/round/saturate by value.
  function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y);
    longint unsigned ma, mb, prod, rem, half, fr;
    int e, sh;
    logic s;
    s    = x[31] ^ y[31];
    ma   = 64'h800000 + longint'(x[22:0]);
    mb   = 64'h800000 + longint'(y[22:0]);
    prod = ma * mb;
    e    = int'(x[30:23]) + int'(y[30:23]) - 127;
    if (prod >= (64'd1 << 47)) begin
      sh = 24;
      e  = e + 1;
    end else begin
      sh = 23;
    end
    fr   = (prod >> sh) & 64'h7FFFFF;
    rem  = prod & ((64'd1 << sh) - 1);
    half = 64'd1 << (sh - 1);
    if (round_en && (rem > half || (rem == half && fr[0]))) begin
      fr = fr + 1;
      if (fr == 64'h800000) begin
        fr = 0;
        e  = e + 1;
      end
    end
    if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return 32'h0;
    if (e >= 255) return {s, 8'hFE, 23'h7FFFFF};
    if (e <= 0) return 32'h0;
    return {s, 8'(e), 23'(fr)};
  endfunction

  // One full operation: accept, count busy cycles, check latency and result
  task automatic run_op(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                        input logic [31:0] exp_o);
    int lat, bcnt;
    lat  = 0;
    bcnt = 0;
    @(negedge clk);
    a = xa; b = xb; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (valid) begin
        lat = n;
        break;
      end
      if (busy) bcnt++;
      if (n == 1 || n == 25) chk({tag, " o_hold"}, o, last_o);
    end
    chk({tag, " latency"}, 32'(lat), 32'd26);
    chk({tag, " busy_cycles"}, 32'(bcnt), 32'd25);
    chk({tag, " busy_at_valid"}, {31'b0, busy}, 32'd0);
    chk({tag, " o"}, o, exp_o);
    @(negedge clk);
    chk({tag, " valid_pulse"}, {31'b0, valid}, 32'd0);
    last_o = exp_o;
  endtask

  initial begin
    logic [31:0] ra_v, rb_v, exp1;
    int vcnt;
`ifdef MUL_FP_ITER_ROUND_EN
    round_en = 1'b1;
`else
    round_en = 1'b0;
`endif
    last_o = 32'h0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset valid", {31'b0, valid}, 32'd0);
    chk("reset o", o, 32'h0);
    rst = 1'b0;

    // Directed vectors
    run_op("2x3", 32'h40000000, 32'h40400000, 32'h40C00000);
    run_op("neg", 32'hBF800000, 32'h3F000000, 32'hBF000000);
    run_op("zero", 32'h00000000, 32'h40490FDB, 32'h00000000);
    run_op("ovf", 32'h7F000000, 32'h7F000000, 32'h7F7FFFFF);
    run_op("unf", 32'h01000000, 32'h01000000, 32'h00000000);
    run_op("rnd", 32'h3FC00001, 32'h3F800001, round_en ? 32'h3FC00003 : 32'h3FC00002);
    run_op("model_chk", 32'h3FC00001, 32'h3F800001, model(32'h3FC00001, 32'h3F800001));

    // Random operands, mostly moderate exponents with occasional extremes
    for (int i = 0; i < 16; i++) begin
      ra_v = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
      rb_v = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
      if (i % 5 == 3) ra_v[30:23] = 8'($urandom_range(0, 1) * 250);
      if (i % 7 == 4) rb_v[30:23] = 8'($urandom_range(1, 20));
      run_op("rand", ra_v, rb_v, model(ra_v, rb_v));
    end

    // Start while busy and start during DONE are both ignored
    exp1 = model(32'h40A00000, 32'hC0E00000);
    @(negedge clk);
    a = 32'h40A00000; b = 32'hC0E00000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    a = 32'h3F800000; b = 32'h3F800000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vcnt = 0;
    for (int n = 7; n <= 40 && !valid; n++) @(negedge clk);
    chk("busy_start valid", {31'b0, valid}, 32'd1);
    chk("busy_start o", o, exp1);
    last_o = exp1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (valid) vcnt++;
    end
    chk("ignored starts valid_count", 32'(vcnt), 32'd0);
    chk("ignored starts busy", {31'b0, busy}, 32'd0);

    // Reset mid-operation abandons it
    @(negedge clk);
    a = 32'h40000000; b = 32'h40000000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst busy", {31'b0, busy}, 32'd0);
    chk("midrst valid", {31'b0, valid}, 32'd0);
    chk("midrst o", o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    last_o = 32'h0;
    vcnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (valid) vcnt++;
    end
    chk("midrst valid_count", 32'(vcnt), 32'd0);
    chk("midrst o_after", o, 32'h0);
    run_op("post_rst", 32'h40000000, 32'h40400000, 32'h40C00000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mul_fp_iter.md
MUL_FP_ITER -- requirements
Module: mul_fp_iter

Interface
REQ-001 One clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  request; sampled on rising clk edge while idle.
REQ-005 a  input  32  single-precision operand (sign, 8-bit exponent, 23-bit fraction), captured with start.
REQ-006 b  input  32  second operand, captured with start.
REQ-007 busy  output  1  high from the edge accepting start until the edge raising valid.
REQ-008 valid  output  1  one-cycle pulse marking a new product on o.
REQ-009 o  output  32  product, held stable until the next valid pulse.

Function
REQ-010 Format matches the downstream floating-point adder: hidden 1 always, no denormals/NaN/Inf; exponent field 0 means zero.
REQ-011 States: IDLE, MUL, NORM, DONE; reset state IDLE.
REQ-012 IDLE: start=1 latches a, b; sign = a[31]^b[31]; clears the 48-bit product; loads 5-bit counter with 23; goes to MUL; busy=1.
REQ-013 MUL: shift-add, one multiplier bit per cycle, LSB first, 24 cycles; leaves when counter=0.
REQ-014 NORM: 10-bit signed e = aE + bE - 127; if p[47]=1, fraction = p[46:24] and e+1, else fraction = p[45:23].
REQ-015 NORM saturation: e >= 255 -> o = {sign, 8'hFE, 23'h7FFFFF}; e <= 0 -> o = 32'h0.
REQ-016 NORM zero rule: either operand exponent field 0 -> o = 32'h0 (sign 0).
REQ-017 DONE: valid=1 and busy=0 for exactly one cycle; returns to IDLE.
REQ-018 Fixed latency: valid high in the 26th cycle after the edge sampling start, zero operands included.
REQ-019 start while busy is ignored; queued work is not kept.
REQ-020 start during DONE is ignored; earliest re-accept is the first IDLE cycle.
REQ-021 o changes only on the edge leaving NORM.

Reset
REQ-022 rst=1 forces, immediately and asynchronously: state IDLE, busy=0, valid=0, o=32'h0, counter, product and operand registers 0.
REQ-023 Reset mid-operation abandons the operation; no valid pulse follows for it.

Configuration
REQ-024 Macro MUL_FP_ITER_ROUND_EN defined: NORM rounds to nearest-even using guard and sticky bits from the product remainder; mantissa carry-out increments e before the REQ-015 saturation check.
REQ-025 Macro undefined: fraction truncated, same as the adder; no extra cycles in either build.

Structure
REQ-026 Shared package holds FP field widths (EXP_W=8, FRAC_W=23), BIAS=127, the saturated-max constant and the state enum.
REQ-027 Single module; no sub-module. The shift-add datapath is inline.

Verification
REQ-028 a=0x40000000, b=0x40400000, start pulse -> valid after 26 cycles, o=0x40C00000; busy high for 25 cycles.
REQ-029 a=0xBF800000, b=0x3F000000 -> o=0xBF000000; a=0x00000000, b=0x40490FDB -> o=0x00000000 at the same latency.
REQ-030 a=b=0x7F000000 -> o=0x7F7FFFFF; a=b=0x01000000 -> o=0x00000000.
REQ-031 a=0x3FC00001, b=0x3F800001 -> o=0x3FC00002 without MUL_FP_ITER_ROUND_EN, 0x3FC00003 with it.
REQ-032 Second start 5 cycles after the first -> ignored, only one valid pulse. rst at cycle 10 of an operation -> no valid pulse, o=0. New start after rst release -> correct result at full latency.
